// File: rtl/freq_meter_seg.sv
// Gate-window frequency meter: counts synchronized rising edges of sig_in per gate,
// converts the result to BCD and scans it onto a multiplexed 7-segment display.

module freq_meter_seg_digit (
   input  logic [3:0] code,
   input  logic       blank,
   output logic [7:0] seg
);
   logic [7:0] seg_on;

   // Code 4'hA is the dash shown on overflow.
   always_comb begin
      seg_on = 8'h00;
      case (code)
         4'd0:    seg_on = 8'h3F;
         4'd1:    seg_on = 8'h06;
         4'd2:    seg_on = 8'h5B;
         4'd3:    seg_on = 8'h4F;
         4'd4:    seg_on = 8'h66;
         4'd5:    seg_on = 8'h6D;
         4'd6:    seg_on = 8'h7D;
         4'd7:    seg_on = 8'h07;
         4'd8:    seg_on = 8'h7F;
         4'd9:    seg_on = 8'h6F;
         4'hA:    seg_on = 8'h40;
         default: seg_on = 8'h00;
      endcase
      seg = blank ? 8'hFF : ~seg_on;
   end
endmodule

module freq_meter_seg #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int GATE_MS   = 1000,
   parameter int CNT_W     = 24,
   parameter int DIGITS    = 6,
   parameter int SCAN_FREQ = 200
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sig_in,
   input  logic              hold,
   output logic [CNT_W-1:0]  freq_value,
   output logic              valid,
   output logic              overflow,
   output logic [DIGITS-1:0] seg_sel,
   output logic [7:0]        seg_data
);
   localparam int GATE_CYCLES = CLK_FREQ / 1000 * GATE_MS;
   localparam int SCAN_COUNT  = CLK_FREQ / (SCAN_FREQ * DIGITS) - 1;
   localparam int GATE_W      = $clog2(GATE_CYCLES);
   localparam int SCAN_W      = (SCAN_COUNT > 0) ? $clog2(SCAN_COUNT + 1) : 1;
   localparam int IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int ITER_W      = $clog2(CNT_W + 1);
   localparam int BCD_W       = DIGITS * 4;

   function automatic longint pow10(input int n);
      longint r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   localparam logic [63:0]      MAX_DISP = 64'(pow10(DIGITS) - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   // sync_pipe[1:0] is the synchronizer, sync_pipe[2] the edge-detect history.
   logic [2:0]        sync_pipe;
   logic              rise;
   logic [GATE_W-1:0] gate_cnt;
   logic              gate_end;
   logic [CNT_W-1:0]  edge_cnt;
   logic              sat;
   logic [CNT_W-1:0]  cap;
   logic              cap_sat;
   logic [63:0]       cap_ext;
   logic              start;

   assign rise     = sync_pipe[1] & ~sync_pipe[2];
   assign gate_end = (gate_cnt == GATE_W'(GATE_CYCLES - 1));
   assign start    = gate_end & ~hold;
   assign cap_ext  = 64'(cap);

   // An edge landing on the capture cycle is folded into the captured value.
   always_comb begin
      cap     = edge_cnt;
      cap_sat = sat;
      if (rise) begin
         if (edge_cnt == CNT_MAX) cap_sat = 1'b1;
         else                     cap     = edge_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_pipe  <= '0;
         gate_cnt   <= '0;
         edge_cnt   <= '0;
         sat        <= 1'b0;
         freq_value <= '0;
         valid      <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         sync_pipe <= {sync_pipe[1:0], sig_in};
         valid     <= 1'b0;
         if (gate_end) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            if (!hold) begin
               freq_value <= cap;
               valid      <= 1'b1;
               overflow   <= cap_sat | (cap_ext > MAX_DISP);
            end
         end else begin
            gate_cnt <= gate_cnt + 1'b1;
            if (rise) begin
               if (edge_cnt == CNT_MAX) sat      <= 1'b1;
               else                     edge_cnt <= edge_cnt + 1'b1;
            end
         end
      end
   end

   // Sequential double-dabble: alternate add-3 and shift phases, CNT_W shifts.
   typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

   state_t                  state;
   logic                    add_ph;
   logic [ITER_W-1:0]       iter;
   logic [CNT_W-1:0]        bin;
   logic [DIGITS-1:0][3:0]  bcd;
   logic [DIGITS-1:0][3:0]  bcd_adj;
   logic [DIGITS-1:0][3:0]  disp;

   always_comb begin
      bcd_adj = bcd;
      for (int d = 0; d < DIGITS; d++)
         if (bcd[d] >= 4'd5) bcd_adj[d] = bcd[d] + 4'd3;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         add_ph <= 1'b0;
         iter   <= '0;
         bin    <= '0;
         bcd    <= '0;
         disp   <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               bin    <= cap;
               bcd    <= '0;
               iter   <= '0;
               add_ph <= 1'b1;
               state  <= SHIFT;
            end
            SHIFT: begin
               if (add_ph) begin
                  bcd    <= bcd_adj;
                  add_ph <= 1'b0;
               end else begin
                  {bcd, bin} <= {bcd, bin} << 1;
                  iter       <= iter + 1'b1;
                  add_ph     <= 1'b1;
                  if (iter == ITER_W'(CNT_W - 1)) state <= LOAD;
               end
            end
            LOAD: begin
               for (int d = 0; d < DIGITS; d++)
                  disp[d] <= overflow ? 4'hA : bcd[d];
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Leading-zero blanking: a digit is blank if it and everything above it is zero.
   logic [DIGITS-1:0]      blank;
   logic [DIGITS-1:0][7:0] seg_code;
   logic                   nz_acc;

   always_comb begin
      nz_acc = 1'b0;
      blank  = '0;
      for (int d = DIGITS - 1; d >= 0; d--) begin
         nz_acc   = nz_acc | (disp[d] != 4'd0);
         blank[d] = (d != 0) && !nz_acc;
      end
   end

   for (genvar d = 0; d < DIGITS; d++) begin : g_dig
      freq_meter_seg_digit u_dig (
         .code  (disp[d]),
         .blank (blank[d]),
         .seg   (seg_code[d])
      );
   end

   logic [SCAN_W-1:0] scan_cnt;
   logic [IDX_W-1:0]  scan_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         scan_idx <= '0;
         seg_sel  <= '0;
         seg_data <= 8'hFF;
      end else begin
         if (scan_cnt == SCAN_W'(SCAN_COUNT)) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         seg_sel  <= DIGITS'(1) << scan_idx;
         seg_data <= seg_code[scan_idx];
      end
   end
endmodule

// File: tb/tb_freq_meter_seg.sv
// Directed bench for freq_meter_seg: a 4-digit and a 2-digit instance on a 1 MHz clock.

module tb_freq_meter_seg;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hold = 1'b0;
   logic        sig4 = 1'b0, sig2 = 1'b0;
   logic [15:0] f4, f2;
   logic        v4, v2, o4, o2;
   logic [3:0]  sel4;
   logic [1:0]  sel2;
   logic [7:0]  seg4, seg2;
   int          per4 = 0, per2 = 0, ph4 = 0, ph2 = 0;
   int          n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   freq_meter_seg #(.CLK_FREQ(1_000_000), .GATE_MS(1), .CNT_W(16), .DIGITS(4), .SCAN_FREQ(1000)) u4 (
      .clk(clk), .rst_n(rst_n), .sig_in(sig4), .hold(hold), .freq_value(f4),
      .valid(v4), .overflow(o4), .seg_sel(sel4), .seg_data(seg4));

   freq_meter_seg #(.CLK_FREQ(1_000_000), .GATE_MS(1), .CNT_W(16), .DIGITS(2), .SCAN_FREQ(1000)) u2 (
      .clk(clk), .rst_n(rst_n), .sig_in(sig2), .hold(1'b0), .freq_value(f2),
      .valid(v2), .overflow(o2), .seg_sel(sel2), .seg_data(seg2));

   // Square-wave generators, period in clk cycles (0 = held low).
   initial forever begin
      @(posedge clk); #2;
      if (per4 == 0) begin sig4 = 1'b0; ph4 = 0; end
      else begin ph4 = (ph4 + 1 >= per4) ? 0 : ph4 + 1; sig4 = (ph4 < per4 / 2); end
      if (per2 == 0) begin sig2 = 1'b0; ph2 = 0; end
      else begin ph2 = (ph2 + 1 >= per2) ? 0 : ph2 + 1; sig2 = (ph2 < per2 / 2); end
   end

   task automatic wait_valid(input bit which2, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(which2 ? v2 : v4) && n < 1200);
      if (n >= 1200) n = -1;
   endtask

   task automatic get_digit(input bit which2, input int d, output logic [7:0] v);
      logic [3:0] want;
      int         k;
      want = 4'(1 << d);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while ((which2 ? {2'b00, sel2} : sel4) != want && k < 1200);
      v = (k >= 1200) ? 8'hxx : (which2 ? seg2 : seg4);
   endtask

   task automatic test_reset;
      int n;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (sel4 !== 4'b0000) begin n_err++; $display("FAIL reset_sel got %b exp 0000", sel4); end
      n_cmp++; if (seg4 !== 8'hFF) begin n_err++; $display("FAIL reset_seg got %h exp FF", seg4); end
      n_cmp++; if ({f4, v4, o4} !== 18'd0) begin n_err++; $display("FAIL reset_meas got f=%0d v=%b o=%b exp 0", f4, v4, o4); end
      rst_n = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            n_cmp++; if (sel4 !== 4'b0001 || seg4 !== 8'hC0) begin
               n_err++; $display("FAIL first_clk got sel=%b seg=%h exp 0001/C0", sel4, seg4); end
         end
      end while (!v4 && n < 1200);
      n_cmp++; if (n !== 1000) begin n_err++; $display("FAIL first_valid got %0d cycles exp 1000", n); end
   endtask

   task automatic test_zero;
      int n;
      logic [7:0] d;
      wait_valid(0, n);
      n_cmp++; if (n !== 1000) begin n_err++; $display("FAIL zero_interval got %0d exp 1000", n); end
      n_cmp++; if (f4 !== 16'd0 || o4 !== 1'b0) begin n_err++; $display("FAIL zero_value got %0d/%b exp 0/0", f4, o4); end
      repeat (40) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         get_digit(0, i, d);
         n_cmp++; if (d !== ((i == 0) ? 8'hC0 : 8'hFF)) begin
            n_err++; $display("FAIL zero_digit%0d got %h exp %h", i, d, (i == 0) ? 8'hC0 : 8'hFF); end
      end
   endtask

   task automatic test_period10;
      int n;
      logic [7:0] d;
      logic [7:0] exp_d [4];
      exp_d = '{8'hC0, 8'hC0, 8'hF9, 8'hFF};
      per4 = 10;
      wait_valid(0, n);
      wait_valid(0, n);
      n_cmp++; if (n < 0 || f4 < 16'd99 || f4 > 16'd101 || o4 !== 1'b0) begin
         n_err++; $display("FAIL p10_value got %0d/%b (n=%0d) exp 100/0", f4, o4, n); end
      repeat (40) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         get_digit(0, i, d);
         n_cmp++; if (d !== exp_d[i]) begin n_err++; $display("FAIL p10_digit%0d got %h exp %h", i, d, exp_d[i]); end
      end
   endtask

   task automatic test_hold;
      int n, nv, nchg;
      logic [7:0] d;
      per4 = 4;
      wait_valid(0, n);
      wait_valid(0, n);
      n_cmp++; if (f4 !== 16'd250) begin n_err++; $display("FAIL p4_value got %0d exp 250", f4); end
      repeat (40) @(negedge clk);
      get_digit(0, 2, d);
      n_cmp++; if (d !== 8'hA4) begin n_err++; $display("FAIL p4_digit2 got %h exp A4", d); end
      get_digit(0, 1, d);
      n_cmp++; if (d !== 8'h92) begin n_err++; $display("FAIL p4_digit1 got %h exp 92", d); end
      wait_valid(0, n);
      hold = 1'b1;
      per4 = 8;
      nv = 0; nchg = 0;
      for (int i = 0; i < 3050; i++) begin
         @(negedge clk);
         if (v4) nv++;
         if (f4 != 16'd250) nchg++;
      end
      n_cmp++; if (nv !== 0) begin n_err++; $display("FAIL hold_valid got %0d pulses exp 0", nv); end
      n_cmp++; if (nchg !== 0) begin n_err++; $display("FAIL hold_value got %0d changed cycles exp 0", nchg); end
      get_digit(0, 2, d);
      n_cmp++; if (d !== 8'hA4) begin n_err++; $display("FAIL hold_digit2 got %h exp A4", d); end
      hold = 1'b0;
      wait_valid(0, n);
      n_cmp++; if (n < 0 || f4 !== 16'd125) begin n_err++; $display("FAIL release_value got %0d (n=%0d) exp 125", f4, n); end
   endtask

   task automatic test_overflow;
      int n;
      logic [7:0] d;
      per2 = 4;
      wait_valid(1, n);
      wait_valid(1, n);
      n_cmp++; if (n < 0 || f2 !== 16'd250 || o2 !== 1'b1) begin
         n_err++; $display("FAIL ovf_flag got %0d/%b exp 250/1", f2, o2); end
      repeat (40) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         get_digit(1, i, d);
         n_cmp++; if (d !== 8'hBF) begin n_err++; $display("FAIL ovf_digit%0d got %h exp BF", i, d); end
      end
      per2 = 0;
      wait_valid(1, n);
      wait_valid(1, n);
      n_cmp++; if (n < 0 || f2 !== 16'd0 || o2 !== 1'b0) begin
         n_err++; $display("FAIL ovf_clear got %0d/%b exp 0/0", f2, o2); end
      repeat (40) @(negedge clk);
      get_digit(1, 0, d);
      n_cmp++; if (d !== 8'hC0) begin n_err++; $display("FAIL ovf_clr_digit0 got %h exp C0", d); end
      get_digit(1, 1, d);
      n_cmp++; if (d !== 8'hFF) begin n_err++; $display("FAIL ovf_clr_digit1 got %h exp FF", d); end
   endtask

   task automatic test_reset_midconv;
      int n;
      wait_valid(0, n);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (sel4 !== 4'b0000 || seg4 !== 8'hFF) begin
         n_err++; $display("FAIL midrst_disp got sel=%b seg=%h exp 0000/FF", sel4, seg4); end
      n_cmp++; if ({f4, v4, o4} !== 18'd0) begin n_err++; $display("FAIL midrst_meas got f=%0d v=%b o=%b exp 0", f4, v4, o4); end
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            n_cmp++; if (seg4 !== 8'hC0) begin n_err++; $display("FAIL midrst_digit0 got %h exp C0", seg4); end
         end
      end while (!v4 && n < 1200);
      n_cmp++; if (n !== 1000) begin n_err++; $display("FAIL midrst_valid got %0d cycles exp 1000", n); end
      n_cmp++; if (f4 < 16'd124 || f4 > 16'd126) begin n_err++; $display("FAIL midrst_value got %0d exp 125", f4); end
   endtask

   task automatic test_scan;
      int run, runs, bad_hot, bad_dwell, bad_seq, k;
      logic [3:0] prev, nxt;
      prev = sel4;
      k = 0;
      do begin @(negedge clk); k++; end while (sel4 == prev && k < 300);
      prev = sel4; run = 1; runs = 0; bad_hot = 0; bad_dwell = 0; bad_seq = 0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (!$onehot(sel4)) bad_hot++;
         if (sel4 == prev) run++;
         else begin
            nxt = (prev == 4'b1000) ? 4'b0001 : (prev << 1);
            if (run != 250) bad_dwell++;
            if (sel4 != nxt) bad_seq++;
            runs++; prev = sel4; run = 1;
         end
      end
      n_cmp++; if (bad_hot !== 0) begin n_err++; $display("FAIL scan_onehot got %0d bad cycles exp 0", bad_hot); end
      n_cmp++; if (bad_dwell !== 0) begin n_err++; $display("FAIL scan_dwell got %0d bad dwells exp 0", bad_dwell); end
      n_cmp++; if (bad_seq !== 0) begin n_err++; $display("FAIL scan_order got %0d bad steps exp 0", bad_seq); end
      n_cmp++; if (runs !== 80) begin n_err++; $display("FAIL scan_steps got %0d exp 80", runs); end
   endtask

   initial begin
      test_reset;
      test_zero;
      test_period10;
      test_hold;
      test_overflow;
      test_reset_midconv;
      test_scan;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/freq_meter_seg.md
# freq_meter_seg

Parametrised frequency meter with multiplexed 7-segment readout for the webcamera peripheral. It counts rising edges of an asynchronous input over a fixed gate window in the `clk` domain. It saturates and flags overflow, converts the result to BCD with a sequential double-dabble, and drives a DIGITS-wide common-select LED display with leading-zero blanking. It replaces fixed 3-digit, 1 s gate meters with a configurable one that does no counting in the measured clock domain.

## Interface
- CLK_FREQ, 50_000_000, `clk` frequency in Hz.
- GATE_MS, 1000, gate window in ms. GATE_CYCLES = CLK_FREQ/1000*GATE_MS. Requires GATE_CYCLES > 4*DIGITS*4+CNT_W+8.
- CNT_W, 24, edge counter / result width.
- DIGITS, 6, display digits (1..8).
- SCAN_FREQ, 200, full-display refresh rate in Hz. SCAN_COUNT = CLK_FREQ/(SCAN_FREQ*DIGITS)-1.
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- sig_in, in, 1, measured signal. Asynchronous to `clk`, frequency < CLK_FREQ/4.
- hold, in, 1, level. While high, `freq_value` and the display are frozen; measurement continues.
- freq_value, out, CNT_W, last completed gate count (edges per gate).
- valid, out, 1, one-cycle pulse when `freq_value` updates.
- overflow, out, 1, last gate saturated the counter or exceeded 10^DIGITS-1.
- seg_sel, out, DIGITS, one-hot digit enable, active-high. Bit 0 is the least significant digit.
- seg_data, out, 8, segments {dp,g,f,e,d,c,b,a}, active-low. dp is always off.

## Operation
- Input path: 2-FF synchronizer on `sig_in`, then a registered edge detect. One count enable per rising edge.
- Gate counter runs 0..GATE_CYCLES-1 continuously from reset release.
- Edge counter increments per edge and saturates at 2^CNT_W-1, setting a sticky `sat` bit.
- At gate_cnt == GATE_CYCLES-1:
  - Capture count. An edge in this same cycle is included.
  - Clear the counter, so the next cycle starts at 0. An edge on the clear cycle counts into the new window.
  - Clear `sat`.
- Capture, when `hold`=0:
  - `freq_value` <= count; `valid` pulses.
  - `overflow` <= sat | (count > 10^DIGITS-1).
  - Start the conversion FSM.
- Capture with `hold`=1: `freq_value`, `valid`, `overflow` and the conversion FSM are unchanged and not started.
- Conversion FSM:
  - States: IDLE -> SHIFT (CNT_W iterations, each one add-3 cycle plus one shift cycle) -> LOAD -> IDLE.
  - LOAD copies the DIGITS×4-bit BCD register into the display register.
  - If `overflow`, LOAD instead writes a dash code (segment g only) for every digit.
- Scan: a timer counts 0..SCAN_COUNT. At SCAN_COUNT the digit index advances 0..DIGITS-1 and wraps to 0.
- seg_sel/seg_data are registered from the index and the display register.
- Blanking:
  - A digit above the most significant nonzero digit outputs 8'hFF while its `seg_sel` bit is still asserted.
  - Digit 0 is never blanked, so value 0 shows "0".
- Segment codes: 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F (active-high), inverted on output. Dash = 40 inverted = 8'hBF.

## Timing
- Reset values:
  - `seg_sel` = 0, `seg_data` = 8'hFF.
  - `freq_value` = 0, `valid` = 0, `overflow` = 0.
  - Display register holds BCD 0; gate, edge, scan and FSM counters are 0; FSM in IDLE.
- The first `clk` after reset release drives `seg_sel` = 1 with digit 0 = "0".
- Edge to count: 3 `clk` cycles (2 sync plus detect).
- Capture to `valid`: `valid` and `freq_value` are registered on the cycle after gate_cnt == GATE_CYCLES-1.
- Capture to display update: at most 2*CNT_W+2 cycles.
- Digit dwell: SCAN_COUNT+1 cycles.
- `hold` is sampled on the capture cycle only. Releasing `hold` mid-gate takes effect at the next capture.
- Reset mid-conversion or mid-gate aborts everything to reset values. No partial result is published.

## Test plan
- Sim params: CLK_FREQ=1_000_000, GATE_MS=1 (GATE_CYCLES=1000), DIGITS=4, CNT_W=16, SCAN_FREQ=1000 (SCAN_COUNT=249).
- After reset, `sig_in`=0 -> every gate `freq_value`=0, `valid` pulses every 1000 cycles, display scans "   0" (digits 1..3 = 8'hFF, digit 0 = 8'hC0).
- `sig_in` period 10 clk -> `freq_value`=100 ±1, `overflow`=0. Display digit2=8'hF9, digit1=digit0=8'hC0, digit3=8'hFF.
- `sig_in` period 4 clk (250 edges), then `hold`=1 for 3 gates while period becomes 8 -> `freq_value` and display stay 250 and `valid` stays low during hold. After release, the next capture gives 125.
- Max-rate input with DIGITS=2 (count ≥ 100) -> `overflow`=1, all digits 8'hBF. Returning to `sig_in`=0 -> `overflow`=0 and display "0" after the next gate.
- Assert `rst_n`=0 mid-conversion -> outputs reset values in the same cycle. After release the first `valid` comes at the end of a full 1000-cycle gate.
- Check that `seg_sel` is one-hot (0 only in reset) for 20 full scan cycles, with each digit dwelling 250 cycles.
